// File: rtl/nic_pe_port.sv
// Network interface between a processing element and one mesh router PE port.
// Single-entry tx and rx buffers behind a 4-register memory-mapped processor interface.
module nic_pe_port #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            addr,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic [DATA_WIDTH-1:0] d_out,
    input  logic                  nicEn,
    input  logic                  nicWrEn,
    input  logic                  polarity,
    output logic                  pesi,
    output logic [DATA_WIDTH-1:0] pedi,
    input  logic                  peri,
    input  logic                  peso,
    input  logic [DATA_WIDTH-1:0] pedo,
    output logic                  pero
);

    localparam logic [1:0] ADDR_RX_BUF  = 2'b00;
    localparam logic [1:0] ADDR_RX_STAT = 2'b01;
    localparam logic [1:0] ADDR_TX_BUF  = 2'b10;
    localparam logic [1:0] ADDR_TX_STAT = 2'b11;

    logic [DATA_WIDTH-1:0] tx_buf_q, tx_buf_d;
    logic                  tx_full_q, tx_full_d;
    logic [DATA_WIDTH-1:0] rx_buf_q, rx_buf_d;
    logic                  rx_full_q, rx_full_d;
    logic                  pesi_q, pesi_d;
    logic [DATA_WIDTH-1:0] pedi_q, pedi_d;

    logic tx_write;
    logic tx_launch;
    logic rx_read;
    logic rx_accept;

    // A flit may only be launched in the phase opposite its vc, so it is
    // presented to the router in the cycle where polarity matches the vc.
    assign tx_write  = nicEn & nicWrEn & (addr == ADDR_TX_BUF) & ~tx_full_q;
    assign tx_launch = tx_full_q & peri & (polarity != tx_buf_q[DATA_WIDTH-1]);
    assign rx_read   = nicEn & ~nicWrEn & (addr == ADDR_RX_BUF);
    assign rx_accept = peso & ~rx_full_q;

    always_comb begin
        tx_buf_d  = tx_buf_q;
        tx_full_d = tx_full_q;
        pesi_d    = tx_launch;
        pedi_d    = pedi_q;
        if (tx_launch) begin
            pedi_d    = tx_buf_q;
            tx_full_d = 1'b0;
        end
        if (tx_write) begin
            tx_buf_d  = d_in;
            tx_full_d = 1'b1;
        end
    end

    // Arrival and read-clear are mutually exclusive: arrival needs rx_full=0.
    always_comb begin
        rx_buf_d  = rx_buf_q;
        rx_full_d = rx_full_q;
        if (rx_accept) begin
            rx_buf_d  = pedo;
            rx_full_d = 1'b1;
        end else if (rx_read) begin
            rx_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_buf_q  <= '0;
            tx_full_q <= 1'b0;
            rx_buf_q  <= '0;
            rx_full_q <= 1'b0;
            pesi_q    <= 1'b0;
            pedi_q    <= '0;
        end else begin
            tx_buf_q  <= tx_buf_d;
            tx_full_q <= tx_full_d;
            rx_buf_q  <= rx_buf_d;
            rx_full_q <= rx_full_d;
            pesi_q    <= pesi_d;
            pedi_q    <= pedi_d;
        end
    end

    always_comb begin
        d_out = '0;
        if (nicEn && !nicWrEn) begin
            case (addr)
                ADDR_RX_BUF:  d_out = rx_buf_q;
                ADDR_RX_STAT: d_out = {{(DATA_WIDTH-1){1'b0}}, rx_full_q};
                ADDR_TX_STAT: d_out = {{(DATA_WIDTH-1){1'b0}}, tx_full_q};
                default:      d_out = '0;
            endcase
        end
    end

    assign pesi = pesi_q;
    assign pedi = pedi_q;
    assign pero = ~rx_full_q;

endmodule
